// File: rtl/obi_memory_slv_model_pkg.sv
// Shared constants and helpers for the OBI slave memory model.
package obi_memory_slv_model_pkg;

  localparam logic [5:0] ATOP_NONE = 6'h00;

  function automatic bit legal_data_width(input int unsigned w);
    return (w == 32) || (w == 64);
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Single-bit odd parity is simply the inverse of the bit.
  function automatic logic odd_par(input logic b);
    return ~b;
  endfunction

endpackage

// File: rtl/obi_memory_slv_model_fifo.sv
// In-order response FIFO; each entry carries a countdown that gates when it may leave.
module obi_memory_slv_model_fifo #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     head_ready,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(LATENCY + 1);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(LATENCY - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [PW:0]     OCC_ONE  = (PW + 1)'(1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [CNTW-1:0]  cnt_q  [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]      count_q, count_d;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) wr_d = wr_q + PTR_ONE;
    if (pop)  rd_d = rd_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + OCC_ONE;
      2'b01:   count_d = count_q - OCC_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Free-running countdown on every slot; a fresh push overrides its slot.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (cnt_q[PW'(i)] != '0) cnt_q[PW'(i)] <= cnt_q[PW'(i)] - CNT_ONE;
    end
    if (push) begin
      data_q[wr_q] <= push_data;
      cnt_q[wr_q]  <= CNT_LOAD;
    end
  end

  assign head_ready = (count_q != '0) && (cnt_q[rd_q] == '0);
  assign head_data  = data_q[rd_q];
  assign count      = count_q;

endmodule

// File: rtl/obi_memory_slv_model.sv
// OBI slave memory model: word array, address decode, grant and parity around a response FIFO.
module obi_memory_slv_model
  import obi_memory_slv_model_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned RSP_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req,
  output logic                    gnt,
  output logic                    gntpar,
  input  logic                    reqpar,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [ID_WIDTH-1:0]     aid,
  input  logic [5:0]              atop,
  input  logic                    stall,
  output logic                    rvalid,
  output logic                    rvalidpar,
  input  logic                    rready,
  input  logic                    rreadypar,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic [ID_WIDTH-1:0]     rid,
  output logic                    exokay,
  output logic                    par_err
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (!legal_data_width(DATA_WIDTH) || !is_pow2(DEPTH) || (DEPTH < 2) ||
      !is_pow2(MEM_WORDS) || (RSP_LATENCY < 1)) begin : g_param_check
    $error("obi_memory_slv_model: illegal parameter combination");
  end

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
    logic [ID_WIDTH-1:0]   rid;
  } entry_t;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [IDX_W-1:0]      idx;
  logic                  in_range, bad, accept, retire, head_ready;
  logic [CW-1:0]         fifo_count;
  entry_t                push_e, head_e;
  logic                  par_err_q, par_err_d;

  assign idx      = addr[IDX_W+OFF_W-1:OFF_W];
  assign in_range = (addr >> (IDX_W + OFF_W)) == '0;
  assign bad      = !in_range || (atop != ATOP_NONE);

  // Gated by reset_n so gnt reads low for the whole reset window.
  assign gnt    = reset_n & req & ~stall & (fifo_count != FULL);
  assign accept = req & gnt;
  assign retire = rvalid & rready;

  always_comb begin
    push_e.rdata = (we || bad) ? '0 : mem_q[idx];
    push_e.err   = bad;
    push_e.rid   = aid;
  end

  always_ff @(posedge clk) begin
    if (accept && we && !bad) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  obi_memory_slv_model_fifo #(
    .WIDTH   ($bits(entry_t)),
    .DEPTH   (DEPTH),
    .LATENCY (RSP_LATENCY)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (accept),
    .push_data  (push_e),
    .pop        (retire),
    .head_ready (head_ready),
    .head_data  (head_e),
    .count      (fifo_count)
  );

  assign rvalid    = head_ready;
  assign rdata     = rvalid ? head_e.rdata : '0;
  assign err       = rvalid & head_e.err;
  assign rid       = rvalid ? head_e.rid : '0;
  assign exokay    = 1'b0;
  assign gntpar    = odd_par(gnt);
  assign rvalidpar = odd_par(rvalid);

  assign par_err_d = (reqpar == req) || (rreadypar == rready);

  always_ff @(posedge clk) begin
    if (!reset_n) par_err_q <= 1'b0;
    else          par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;

endmodule
